// File: rtl/avmm_mem_fill_check_master_pkg.sv
// Shared definitions for the memory fill/check Avalon-MM master:
// FSM state encoding, mode bit constants and the test pattern generator.
package avmm_mem_fill_check_master_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_WRITE = 3'd1,
    ST_READ  = 3'd2,
    ST_DRAIN = 3'd3,
    ST_FIN   = 3'd4
  } state_t;

  localparam logic [1:0] MODE_NOP   = 2'b00;
  localparam logic [1:0] MODE_FILL  = 2'b01;
  localparam logic [1:0] MODE_CHECK = 2'b10;

  // Pattern word for index idx: seed XOR zero-extended index.
  // Callers truncate to their data width (up to 64 bits).
  function automatic logic [63:0] exp_pat(input logic [63:0] seed, input logic [63:0] idx);
    return seed ^ idx;
  endfunction

endpackage

// File: rtl/avmm_mem_fill_check_master.sv
// Avalon-MM master that fills a word range of on-chip memory with a
// seed-derived pattern, reads it back with up to MAX_PENDING reads in
// flight, and counts mismatches.
module avmm_mem_fill_check_master
  import avmm_mem_fill_check_master_pkg::*;
#(
  parameter int ADDR_W      = 13,
  parameter int DATA_W      = 32,
  parameter int MAX_PENDING = 4,
  parameter int ERR_W       = 16
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic [1:0]            mode,
  input  logic [ADDR_W-1:0]     base_addr,
  input  logic [ADDR_W:0]       word_count,
  input  logic [DATA_W-1:0]     seed,
  output logic                  busy,
  output logic                  done,
  output logic [ERR_W-1:0]      error_count,
  output logic [ADDR_W-1:0]     first_err_addr,
  output logic [ADDR_W-1:0]     avm_address,
  output logic [DATA_W/8-1:0]   avm_byteenable,
  output logic                  avm_read,
  output logic                  avm_write,
  output logic [DATA_W-1:0]     avm_writedata,
  input  logic                  avm_waitrequest,
  input  logic [DATA_W-1:0]     avm_readdata,
  input  logic                  avm_readdatavalid
);

  localparam int CNT_W  = ADDR_W + 1;
  localparam int PEND_W = 4;

  state_t              state;
  logic                do_check;
  logic [ADDR_W-1:0]   base_q;
  logic [CNT_W-1:0]    count_q;
  logic [DATA_W-1:0]   seed_q;
  logic [CNT_W-1:0]    issue_idx;
  logic [CNT_W-1:0]    chk_idx;
  logic [PEND_W-1:0]   pending;

  logic                wr_acc;
  logic                rd_acc;
  logic                rsp_vld;
  logic                start_ok;
  logic                rd_room;
  logic [PEND_W-1:0]   pend_next;
  logic [CNT_W-1:0]    issue_next;

  // Word address of index idx; wraps past the top of the address space.
  function automatic logic [ADDR_W-1:0] addr_of(input logic [ADDR_W-1:0] base,
                                                input logic [CNT_W-1:0]  idx);
    return base + idx[ADDR_W-1:0];
  endfunction

  function automatic logic [DATA_W-1:0] data_of(input logic [DATA_W-1:0] s,
                                                input logic [CNT_W-1:0]  idx);
    return DATA_W'(exp_pat(64'(s), 64'(idx)));
  endfunction

  assign avm_byteenable = '1;

  assign wr_acc     = avm_write & ~avm_waitrequest;
  assign rd_acc     = avm_read & ~avm_waitrequest;
  // Responses with nothing outstanding (e.g. left over from before a reset) are dropped.
  assign rsp_vld    = avm_readdatavalid & (pending != '0);
  assign pend_next  = pending + PEND_W'(rd_acc) - PEND_W'(rsp_vld);
  assign issue_next = issue_idx + CNT_W'(wr_acc | rd_acc);
  assign rd_room    = pend_next < PEND_W'(MAX_PENDING);
  assign start_ok   = start && (mode != MODE_NOP) && (word_count != '0);

  // Control FSM: issues writes then reads, tracks outstanding reads, owns bus outputs.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state         <= ST_IDLE;
      busy          <= 1'b0;
      done          <= 1'b0;
      avm_read      <= 1'b0;
      avm_write     <= 1'b0;
      avm_address   <= '0;
      avm_writedata <= '0;
      pending       <= '0;
      issue_idx     <= '0;
      do_check      <= 1'b0;
      base_q        <= '0;
      count_q       <= '0;
      seed_q        <= '0;
    end else begin
      pending <= pend_next;
      unique case (state)
        ST_IDLE: begin
          if (start_ok) begin
            base_q      <= base_addr;
            count_q     <= word_count;
            seed_q      <= seed;
            do_check    <= (mode & MODE_CHECK) != 2'b00;
            issue_idx   <= '0;
            busy        <= 1'b1;
            avm_address <= base_addr;
            if ((mode & MODE_FILL) != 2'b00) begin
              state         <= ST_WRITE;
              avm_write     <= 1'b1;
              avm_writedata <= seed;
            end else begin
              state    <= ST_READ;
              avm_read <= 1'b1;
            end
          end else if (start) begin
            // Nothing to do: report completion without touching the bus.
            state <= ST_FIN;
            done  <= 1'b1;
          end
        end
        ST_WRITE: begin
          if (wr_acc) begin
            if (issue_next == count_q) begin
              avm_write <= 1'b0;
              issue_idx <= '0;
              if (do_check) begin
                state       <= ST_READ;
                avm_read    <= 1'b1;
                avm_address <= base_q;
              end else begin
                state <= ST_FIN;
                done  <= 1'b1;
                busy  <= 1'b0;
              end
            end else begin
              issue_idx     <= issue_next;
              avm_address   <= addr_of(base_q, issue_next);
              avm_writedata <= data_of(seed_q, issue_next);
            end
          end
        end
        ST_READ: begin
          // While stalled, issue_next and pend_next cannot grow, so request and
          // address stay stable; read only drops after an accepting edge.
          issue_idx <= issue_next;
          if (rd_acc && (issue_next == count_q)) begin
            avm_read <= 1'b0;
            state    <= ST_DRAIN;
          end else begin
            avm_read    <= rd_room;
            avm_address <= addr_of(base_q, issue_next);
          end
        end
        ST_DRAIN: begin
          if (pend_next == '0) begin
            state <= ST_FIN;
            done  <= 1'b1;
            busy  <= 1'b0;
          end
        end
        ST_FIN: begin
          done  <= 1'b0;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Compare in-order read responses against the pattern and record errors.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      error_count    <= '0;
      first_err_addr <= '0;
      chk_idx        <= '0;
    end else if ((state == ST_IDLE) && start_ok) begin
      error_count    <= '0;
      first_err_addr <= '0;
      chk_idx        <= '0;
    end else if (rsp_vld) begin
      chk_idx <= chk_idx + CNT_W'(1);
      if (avm_readdata != data_of(seed_q, chk_idx)) begin
        if (error_count != '1) error_count <= error_count + ERR_W'(1);
        if (error_count == '0) first_err_addr <= addr_of(base_q, chk_idx);
      end
    end
  end

endmodule

// File: tb/tb_avmm_mem_fill_check_master.sv
// Bench for avmm_mem_fill_check_master: memory slave model with optional
// random stalls and late responses, write/read scoreboards, and a vector table.
module tb_avmm_mem_fill_check_master;

  localparam int AW   = 13;
  localparam int DW   = 32;
  localparam int NMAX = 4;
  localparam int EW   = 16;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          start;
  logic [1:0]    mode;
  logic [AW-1:0] base_addr;
  logic [AW:0]   word_count;
  logic [DW-1:0] seed;
  logic          busy, done;
  logic [EW-1:0] error_count;
  logic [AW-1:0] first_err_addr;
  logic [AW-1:0] avm_address;
  logic [DW/8-1:0] avm_byteenable;
  logic          avm_read, avm_write;
  logic [DW-1:0] avm_writedata;
  logic          avm_waitrequest;
  logic [DW-1:0] avm_readdata;
  logic          avm_readdatavalid;

  avmm_mem_fill_check_master #(.ADDR_W(AW), .DATA_W(DW), .MAX_PENDING(NMAX), .ERR_W(EW)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .mode(mode), .base_addr(base_addr),
    .word_count(word_count), .seed(seed), .busy(busy), .done(done),
    .error_count(error_count), .first_err_addr(first_err_addr),
    .avm_address(avm_address), .avm_byteenable(avm_byteenable), .avm_read(avm_read),
    .avm_write(avm_write), .avm_writedata(avm_writedata), .avm_waitrequest(avm_waitrequest),
    .avm_readdata(avm_readdata), .avm_readdatavalid(avm_readdatavalid)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]    mode;
    logic [AW-1:0] base;
    logic [AW:0]   cnt;
    logic [DW-1:0] seed;
    bit            stall;
    bit            late;
    int            corrupt;
    int            exp_err;
    logic [AW-1:0] exp_first;
  } vec_t;

  typedef struct { logic [AW-1:0] a; logic [DW-1:0] d; } wr_t;
  typedef struct { logic [DW-1:0] d; int due; } rsp_t;

  int tests = 0;
  int fails = 0;

  logic [DW-1:0] mem [0:(1<<AW)-1];
  wr_t           wq[$];
  logic [AW-1:0] rq[$];
  rsp_t          rsp_q[$];
  bit            stall_en = 1'b0;
  bit            corrupt_late = 1'b0;
  int            lat_min = 1;
  int            lat_max = 1;
  int            outstanding = 0;
  int            cyc = 0;

  vec_t vecs[10];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Slave model: drives waitrequest/readdatavalid on the falling edge so the
  // accept decision for the next rising edge is known here.
  initial begin
    logic          prev_req, prev_rd, prev_wr, prev_wait, w;
    logic [AW-1:0] prev_addr;
    logic [DW-1:0] prev_wdata;
    int            due, last_due, l;
    wr_t           e;
    rsp_t          r;
    logic [AW-1:0] ea;
    prev_req = 0; prev_rd = 0; prev_wr = 0; prev_wait = 0; prev_addr = '0; prev_wdata = '0;
    last_due = 0;
    avm_waitrequest = 1'b0; avm_readdatavalid = 1'b0; avm_readdata = '0;
    forever begin
      @(negedge clk);
      cyc++;
      if (reset_n && prev_req && prev_wait) begin
        chk("stall_stable_rd", 64'(avm_read), 64'(prev_rd));
        chk("stall_stable_wr", 64'(avm_write), 64'(prev_wr));
        chk("stall_stable_addr", 64'(avm_address), 64'(prev_addr));
        if (prev_wr) chk("stall_stable_wdata", 64'(avm_writedata), 64'(prev_wdata));
      end
      if (avm_read || avm_write) chk("rd_wr_exclusive", 64'(avm_read && avm_write), 64'(0));
      w = stall_en ? 1'($urandom_range(0, 1)) : 1'b0;
      avm_waitrequest = w;
      if (avm_write && !w) begin
        mem[avm_address] = avm_writedata;
        if (wq.size() == 0) begin
          tests++; fails++;
          $display("FAIL unexpected_write: addr 0x%0h data 0x%0h, expected no write", avm_address, avm_writedata);
        end else begin
          e = wq.pop_front();
          chk("wr_addr", 64'(avm_address), 64'(e.a));
          chk("wr_data", 64'(avm_writedata), 64'(e.d));
        end
      end
      if (avm_read && !w) begin
        if (rq.size() == 0) begin
          tests++; fails++;
          $display("FAIL unexpected_read: addr 0x%0h, expected no read", avm_address);
        end else begin
          ea = rq.pop_front();
          chk("rd_addr", 64'(avm_address), 64'(ea));
        end
        l = $urandom_range(lat_min, lat_max);
        due = cyc + l;
        if (due <= last_due) due = last_due + 1;
        last_due = due;
        r.d = mem[avm_address];
        r.due = due;
        rsp_q.push_back(r);
        outstanding++;
      end
      if (rsp_q.size() > 0 && rsp_q[0].due <= cyc) begin
        r = rsp_q.pop_front();
        avm_readdatavalid = 1'b1;
        avm_readdata = corrupt_late ? (r.d ^ 32'h1) : r.d;
        outstanding--;
      end else begin
        avm_readdatavalid = 1'b0;
        avm_readdata = $urandom;
      end
      if (outstanding > 0) chk("pending_limit", 64'(outstanding <= NMAX), 64'(1));
      prev_req = avm_read || avm_write;
      prev_rd = avm_read; prev_wr = avm_write; prev_wait = w;
      prev_addr = avm_address; prev_wdata = avm_writedata;
    end
  end

  task automatic run_vec(input vec_t v, input bit poke);
    bit seen;
    bit active;
    stall_en = v.stall;
    lat_min = 1;
    lat_max = v.late ? 3 : 1;
    if (v.corrupt >= 0) mem[AW'(int'(v.base) + v.corrupt)] ^= 32'h0000_0100;
    active = (v.mode != 2'b00) && (v.cnt != 0);
    if (active && v.mode[0])
      for (int i = 0; i < int'(v.cnt); i++) wq.push_back('{AW'(int'(v.base) + i), v.seed ^ DW'(i)});
    if (active && v.mode[1])
      for (int i = 0; i < int'(v.cnt); i++) rq.push_back(AW'(int'(v.base) + i));
    @(negedge clk);
    start = 1'b1; mode = v.mode; base_addr = v.base; word_count = v.cnt; seed = v.seed;
    @(negedge clk);
    // Valid-looking junk on the inputs: must have no effect once latched.
    start = 1'b0; mode = 2'b11; base_addr = AW'($urandom); word_count = 14'd5; seed = $urandom;
    chk("busy_after_start", 64'(busy), 64'(active));
    seen = 1'b0;
    for (int k = 0; k < 2000; k++) begin
      if (done) begin seen = 1'b1; break; end
      start = poke && (k == 2);
      @(negedge clk);
    end
    start = 1'b0;
    chk("done_seen", 64'(seen), 64'(1));
    chk("busy_at_done", 64'(busy), 64'(0));
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("done_one_cycle", 64'(done), 64'(0));
      chk("idle_after_done", 64'(busy), 64'(0));
    end
    chk("writes_left", 64'(wq.size()), 64'(0));
    chk("reads_left", 64'(rq.size()), 64'(0));
    chk("error_count", 64'(error_count), 64'(v.exp_err));
    if (v.exp_err != 0) chk("first_err_addr", 64'(first_err_addr), 64'(v.exp_first));
    wq.delete();
    rq.delete();
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t v;
    bit   hit;
    for (int i = 0; i < (1 << AW); i++) mem[i] = '0;
    //          mode   base     cnt     seed          stl lat corrupt err first
    vecs[0] = '{2'b01, 13'h0010, 14'd4,  32'hA5A5_0000, 0, 0, -1, 0, 13'h0000};
    vecs[1] = '{2'b11, 13'h1FFE, 14'd4,  32'h1234_5678, 0, 0, -1, 0, 13'h0000};
    vecs[2] = '{2'b01, 13'h0100, 14'd8,  32'hCAFE_0000, 0, 0, -1, 0, 13'h0000};
    vecs[3] = '{2'b10, 13'h0100, 14'd8,  32'hCAFE_0000, 0, 0,  2, 1, 13'h0102};
    vecs[4] = '{2'b11, 13'h0200, 14'd20, 32'hDEAD_0000, 1, 1, -1, 0, 13'h0000};
    vecs[5] = '{2'b10, 13'h0200, 14'd3,  32'hDEAD_0001, 0, 0, -1, 3, 13'h0200};
    vecs[6] = '{2'b11, 13'h0040, 14'd0,  32'h0000_0000, 0, 0, -1, 3, 13'h0200};
    vecs[7] = '{2'b00, 13'h0040, 14'd4,  32'h0000_0000, 0, 0, -1, 3, 13'h0200};
    vecs[8] = '{2'b11, 13'h1FFF, 14'd1,  32'h0000_0000, 0, 0, -1, 0, 13'h0000};
    vecs[9] = '{2'b10, 13'h0200, 14'd20, 32'hDEAD_0000, 1, 1, -1, 0, 13'h0000};

    reset_n = 1'b0; start = 1'b0; mode = 2'b00; base_addr = '0; word_count = '0; seed = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_done", 64'(done), 64'(0));
    chk("rst_read", 64'(avm_read), 64'(0));
    chk("rst_write", 64'(avm_write), 64'(0));
    chk("rst_byteenable", 64'(avm_byteenable), 64'(4'hF));
    chk("rst_error_count", 64'(error_count), 64'(0));
    reset_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 10; i++) run_vec(vecs[i], 1'b0);

    // start pulse while busy must be ignored
    v = '{2'b01, 13'h0400, 14'd8, 32'h0BAD_F00D, 0, 0, -1, 0, 13'h0000};
    run_vec(v, 1'b1);

    // reset in the middle of a check with three reads outstanding
    v = '{2'b01, 13'h0300, 14'd8, 32'h5A5A_0000, 0, 0, -1, 0, 13'h0000};
    run_vec(v, 1'b0);
    stall_en = 1'b0; lat_min = 6; lat_max = 6;
    for (int i = 0; i < 8; i++) rq.push_back(AW'(13'h300 + i));
    @(negedge clk);
    start = 1'b1; mode = 2'b10; base_addr = 13'h0300; word_count = 14'd8; seed = 32'h5A5A_0000;
    @(negedge clk);
    start = 1'b0;
    hit = 1'b0;
    for (int k = 0; k < 50; k++) begin
      #1;
      if (outstanding >= 3) begin hit = 1'b1; break; end
      @(negedge clk);
    end
    chk("reached_pending3", 64'(hit), 64'(1));
    reset_n = 1'b0;
    @(negedge clk);
    #1;
    chk("midrst_read", 64'(avm_read), 64'(0));
    chk("midrst_write", 64'(avm_write), 64'(0));
    chk("midrst_busy", 64'(busy), 64'(0));
    chk("midrst_done", 64'(done), 64'(0));
    chk("midrst_address", 64'(avm_address), 64'(0));
    chk("midrst_writedata", 64'(avm_writedata), 64'(0));
    chk("midrst_byteenable", 64'(avm_byteenable), 64'(4'hF));
    reset_n = 1'b1;
    rq.delete();
    corrupt_late = 1'b1;
    hit = 1'b0;
    for (int k = 0; k < 40; k++) begin
      if (rsp_q.size() == 0) begin hit = 1'b1; break; end
      @(negedge clk);
    end
    chk("late_rsp_drained", 64'(hit), 64'(1));
    repeat (2) @(negedge clk);
    chk("late_rsp_ignored", 64'(error_count), 64'(0));
    chk("late_rsp_idle", 64'(busy), 64'(0));
    corrupt_late = 1'b0;
    v = '{2'b10, 13'h0300, 14'd8, 32'h5A5A_0000, 0, 0, -1, 0, 13'h0000};
    run_vec(v, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
